// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: MEM/WB write-back select, 32-entry register file with
// two combinational read ports, same-cycle write-to-read bypass, and a
// retired-write counter.
module pipe_wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wwreg,
    input  logic              wm2reg,
    input  logic [DATA_W-1:0] wmo,
    input  logic [DATA_W-1:0] walu,
    input  logic [4:0]        wrn,
    input  logic [4:0]        rna,
    input  logic [4:0]        rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    output logic [DATA_W-1:0] wdi,
    output logic [CNT_W-1:0]  wcount
);

    localparam int NREG = 32;

    // r1..r31 are real storage; r0 is a constant zero in the read view
    logic [NREG-1:1][DATA_W-1:0] r_regs;
    logic [NREG-1:0][DATA_W-1:0] w_rd;
    logic [CNT_W-1:0]            r_wcount;
    logic                        w_we;
    logic [DATA_W-1:0]           w_wdi;

    assign w_wdi = wm2reg ? wmo : walu;
    // Reset gates the enable so a write in a reset cycle neither commits
    // nor shows up on the read ports.
    assign w_we  = resetn & wwreg & (wrn != 5'd0);

    assign w_rd[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            // Register gi: clear on reset, load write-back data when addressed
            always_ff @(posedge clock) begin
                if (!resetn)
                    r_regs[gi] <= '0;
                else if (w_we && (wrn == 5'(gi)))
                    r_regs[gi] <= w_wdi;
            end
            assign w_rd[gi] = r_regs[gi];
        end
    endgenerate

    // Retired-write counter, wraps naturally at all-ones
    always_ff @(posedge clock) begin
        if (!resetn)
            r_wcount <= '0;
        else if (w_we)
            r_wcount <= r_wcount + 1'b1;
    end

    // Read ports: bypass the in-flight write; w_we already excludes r0,
    // so r0 reads always fall through to the constant zero.
    always_comb begin
        qa = w_rd[rna];
        qb = w_rd[rnb];
        if (w_we && (rna == wrn)) qa = w_wdi;
        if (w_we && (rnb == wrn)) qb = w_wdi;
    end

    assign wdi    = w_wdi;
    assign wcount = r_wcount;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb_pipe_wb_regfile: directed vectors against hand-computed values.
// Built with a 4-bit counter so the wrap point is reachable quickly.
module tb_pipe_wb_regfile;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              resetn;
    logic              wwreg;
    logic              wm2reg;
    logic [DATA_W-1:0] wmo;
    logic [DATA_W-1:0] walu;
    logic [4:0]        wrn;
    logic [4:0]        rna;
    logic [4:0]        rnb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] wdi;
    logic [CNT_W-1:0]  wcount;

    int n_tot;
    int n_bad;

    pipe_wb_regfile #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wmo    (wmo),
        .walu   (walu),
        .wrn    (wrn),
        .rna    (rna),
        .rnb    (rnb),
        .qa     (qa),
        .qb     (qb),
        .wdi    (wdi),
        .wcount (wcount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_tot  = 0;
        n_bad  = 0;
        resetn = 1'b0;
        wwreg  = 1'b0;
        wm2reg = 1'b0;
        wmo    = '0;
        walu   = '0;
        wrn    = '0;
        rna    = 5'd5;
        rnb    = 5'd31;

        // reset then read
        tick();
        chk("rst_qa", qa, 32'h0);
        chk("rst_qb", qb, 32'h0);
        chk("rst_cnt", 32'(wcount), 32'h0);
        resetn = 1'b1;

        // ALU write-back with bypass on port A
        wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h1234_5678; wrn = 5'd3;
        rna = 5'd3; rnb = 5'd5;
        #1;
        chk("alu_byp_qa", qa, 32'h1234_5678);
        chk("alu_wdi", wdi, 32'h1234_5678);
        chk("alu_qb_nobyp", qb, 32'h0);
        tick();
        wwreg = 1'b0;
        #1;
        chk("alu_hold_qa", qa, 32'h1234_5678);
        chk("alu_cnt", 32'(wcount), 32'd1);

        // memory write-back, dual bypass
        wwreg = 1'b1; wm2reg = 1'b1; wmo = 32'hDEAD_BEEF; walu = 32'h1; wrn = 5'd7;
        rna = 5'd7; rnb = 5'd7;
        #1;
        chk("mem_byp_qa", qa, 32'hDEAD_BEEF);
        chk("mem_byp_qb", qb, 32'hDEAD_BEEF);
        chk("mem_wdi", wdi, 32'hDEAD_BEEF);
        tick();
        wwreg = 1'b0; rnb = 5'd3;
        #1;
        chk("mem_r7", qa, 32'hDEAD_BEEF);
        chk("mem_r3", qb, 32'h1234_5678);
        chk("mem_cnt", 32'(wcount), 32'd2);

        // r0 protection
        wwreg = 1'b1; wm2reg = 1'b0; walu = 32'hFFFF_FFFF; wrn = 5'd0; rna = 5'd0;
        #1;
        chk("r0_pre_qa", qa, 32'h0);
        chk("r0_wdi", wdi, 32'hFFFF_FFFF);
        tick();
        chk("r0_post_qa", qa, 32'h0);
        chk("r0_cnt", 32'(wcount), 32'd2);

        // write enable low: no bypass, no write
        wwreg = 1'b0; wrn = 5'd4; walu = 32'hAA; rna = 5'd4;
        #1;
        chk("nowr_pre", qa, 32'h0);
        tick();
        chk("nowr_post", qa, 32'h0);
        chk("nowr_cnt", 32'(wcount), 32'd2);

        // back-to-back writes to the same register
        wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd10; walu = 32'h1; rna = 5'd10;
        #1;
        chk("b2b_1", qa, 32'h1);
        tick();
        walu = 32'h2;
        #1;
        chk("b2b_2", qa, 32'h2);
        tick();
        wwreg = 1'b0;
        #1;
        chk("b2b_hold", qa, 32'h2);
        chk("b2b_cnt", 32'(wcount), 32'd4);

        // reset mid-operation cancels the in-flight write
        wwreg = 1'b1; wrn = 5'd9; walu = 32'h55; rna = 5'd9; rnb = 5'd10;
        tick();
        wwreg = 1'b0;
        #1;
        chk("mid_r9", qa, 32'h55);
        chk("mid_cnt", 32'(wcount), 32'd5);
        resetn = 1'b0; wwreg = 1'b1; wrn = 5'd9; walu = 32'h66;
        #1;
        chk("mid_nobyp", qa, 32'h55);
        tick();
        chk("mid_rst_r9", qa, 32'h0);
        chk("mid_rst_r10", qb, 32'h0);
        chk("mid_rst_cnt", 32'(wcount), 32'd0);
        resetn = 1'b1; wwreg = 1'b0;

        // counter wrap at 2^CNT_W
        rna = 5'd1;
        for (int i = 1; i <= 15; i++) begin
            wwreg = 1'b1; wm2reg = 1'b0; wrn = 5'd1; walu = 32'(i);
            tick();
        end
        wwreg = 1'b0;
        #1;
        chk("wrap_15", 32'(wcount), 32'd15);
        chk("wrap_r1", qa, 32'd15);
        wwreg = 1'b1; wrn = 5'd2; walu = 32'h77;
        tick();
        wwreg = 1'b0;
        #1;
        chk("wrap_0", 32'(wcount), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_wb_regfile.md
Name: pipe_wb_regfile

Overview:
- Write-back end of the MEM/WB stage boundary in the pipelined computer.
- Consumes the MEM/WB register outputs (wwreg, wm2reg, wmo, walu, wrn).
  - Selects the write-back value.
  - Commits it to the 32-entry general register file.
  - Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
- Also keeps a retired-write counter for performance/debug.

Parameters:
DATA_W, 32, width of register data, wmo/walu/qa/qb/wdi
CNT_W, 32, width of the retired-write counter wcount

Ports:
clock  input  1  pipeline clock; all state updates on rising edge
resetn  input  1  synchronous active-low reset, sampled on rising edge of clock
wwreg  input  1  write-back enable from MEM/WB register
wm2reg  input  1  1 = write memory data wmo, 0 = write ALU result walu
wmo  input  DATA_W  memory read data from MEM/WB
walu  input  DATA_W  ALU result from MEM/WB
wrn  input  5  destination register number
rna  input  5  ID read port A register number
rnb  input  5  ID read port B register number
qa  output  DATA_W  read data port A (combinational)
qb  output  DATA_W  read data port B (combinational)
wdi  output  DATA_W  selected write-back data (combinational), for ID-stage forwarding
wcount  output  CNT_W  number of committed register writes

Behaviour:
- wdi = wm2reg ? wmo : walu. Pure mux, no register.
- Write enable we = resetn & wwreg & (wrn != 0).
- Rising edge with resetn=1 and we=1: reg[wrn] <= wdi.
- Register 0 is hardwired:
  - never written;
  - reads of r0 return 0 regardless of bypass.
- Read ports are combinational on rna/rnb, zero-latency.
- Bypass:
  - If we=1 and rna==wrn, qa = wdi (new value visible the same cycle, before the edge).
  - Same rule for qb with rnb.
  - Both ports may bypass simultaneously.
- Otherwise qa = reg[rna] and qb = reg[rnb].
- wwreg=1 with wrn=0: no write, no bypass, counter unchanged.
- wwreg=0: no write and no bypass, regardless of wm2reg/wmo/walu/wrn.
- Rising edge with resetn=0:
  - all reg[1..31] <= 0;
  - wcount <= 0;
  - any pending write that cycle is discarded.
- While resetn=0, bypass is disabled (we=0), so qa/qb show array contents; these are 0 from the first reset edge onward.
- Reset asserted mid-stream cancels the write in that cycle; no partial commit.
- Reset values after the first reset edge: all registers 0, qa=0, qb=0, wcount=0. wdi is unaffected by reset (combinational mux).
- wcount:
  - +1 on each rising edge where we=1;
  - wraps from all-ones to 0 with no saturation and no flag.
- Back-to-back writes to the same register on consecutive cycles: each commits in order, and reads see the newest (bypassed) value.
- Storage: 31 x DATA_W flops (r1..r31) plus CNT_W counter. No latches, no negedge logic.

Test Plan:
- Reset then read: resetn=0 for 1 edge, then rna=5, rnb=31 -> qa=0, qb=0, wcount=0.
- ALU write-back and bypass:
  - wwreg=1, wm2reg=0, walu=0x12345678, wrn=3, rna=3 -> qa=0x12345678 before the edge, wdi=0x12345678;
  - after the edge with wwreg=0, qa still 0x12345678, wcount=1.
- Memory write-back and dual bypass:
  - wwreg=1, wm2reg=1, wmo=0xDEADBEEF, walu=0x1, wrn=7, rna=rnb=7 -> qa=qb=0xDEADBEEF;
  - reg[7]=0xDEADBEEF after the edge.
- r0 protection:
  - wwreg=1, walu=0xFFFFFFFF, wrn=0, rna=0 -> qa=0 before and after the edge, wcount unchanged;
  - wwreg=0 with wrn=4, walu=0xAA -> reg[4] unchanged and no bypass.
- Reset mid-operation:
  - write 0x55 to r9, then assert resetn=0 on a cycle with wwreg=1, wrn=9, walu=0x66;
  - after the edge, reg[9]=0 and wcount=0, and qa (rna=9) never shows 0x66 during reset.
- Counter wrap: force 2^CNT_W-1 committed writes (or preload via a shortened CNT_W=4 build: 15 writes), then one more write -> wcount=0.
